// File: rtl/bch_pkg.sv
// rtl/bch_pkg.sv - BCH(63,56) syndrome constants, state type and GF(2^6) helpers
// Field is GF(2^6) over x^6+x+1; remainder divisor g(x)=x^7+x^6+x^2+1.
package bch_pkg;

   localparam int BCH_N  = 63;
   localparam int BCH_M  = 6;
   localparam int BCH_R  = 7;
   localparam int BCH_CW = $clog2(BCH_N);

   localparam logic [BCH_M-1:0] GF_PRIM = 6'b000011;
   localparam logic [BCH_R:0]   G_POLY  = 8'b1100_0101;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } bch_state_e;

   function automatic logic [BCH_M-1:0] gf_mul_a(input logic [BCH_M-1:0] x);
      logic [BCH_M-1:0] r;
      r = {x[BCH_M-2:0], 1'b0};
      if (x[BCH_M-1]) begin
         r = r ^ GF_PRIM;
      end
      return r;
   endfunction

   function automatic logic [BCH_M-1:0] gf_mul_a2(input logic [BCH_M-1:0] x);
      return gf_mul_a(gf_mul_a(x));
   endfunction

   // One LFSR division step: (r*x + b) mod g(x)
   function automatic logic [BCH_R-1:0] lfsr_step(input logic [BCH_R-1:0] r, input logic b);
      logic [BCH_R:0] t;
      t = {r, b};
      if (t[BCH_R]) begin
         t = t ^ G_POLY;
      end
      return t[BCH_R-1:0];
   endfunction

endpackage

// File: rtl/bch_syndrome_gen_if.sv
// rtl/bch_syndrome_gen_if.sv - serial codeword input and syndrome result bundle
// err_free exists only when BCH_ZERO_FLAG_EN is defined.
interface bch_syndrome_gen_if;
   import bch_pkg::*;

   logic             din;
   logic             din_valid;
   logic             sof;
   logic [BCH_R-1:0] S;
   logic [BCH_M-1:0] s1;
   logic [BCH_M-1:0] s2;
   logic             isEn3;
`ifdef BCH_ZERO_FLAG_EN
   logic             err_free;

   modport master (output din, din_valid, sof, input S, s1, s2, isEn3, err_free);
   modport slave  (input din, din_valid, sof, output S, s1, s2, isEn3, err_free);
`else
   modport master (output din, din_valid, sof, input S, s1, s2, isEn3);
   modport slave  (input din, din_valid, sof, output S, s1, s2, isEn3);
`endif

endinterface

// File: rtl/bch_horner_cell.sv
// rtl/bch_horner_cell.sv - serial Horner evaluator acc <= acc*a^POW ^ din over GF(2^6)
// acc_nxt exposes the value including the current bit so the top can latch a finished frame.
module bch_horner_cell
   import bch_pkg::*;
#(
   parameter int unsigned POW = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             seed,
   input  logic             clr,
   input  logic             din,
   output logic [BCH_M-1:0] acc_nxt
);

   logic [BCH_M-1:0] acc_q;
   logic [BCH_M-1:0] acc_d;
   logic [BCH_M-1:0] acc_mul;

   generate
      if (POW == 2) begin : g_mul_a2
         assign acc_mul = gf_mul_a2(acc_q);
      end else begin : g_mul_a
         assign acc_mul = gf_mul_a(acc_q);
      end
   endgenerate

   always_comb begin
      acc_nxt = (seed ? '0 : acc_mul) ^ {{(BCH_M-1){1'b0}}, din};
      acc_d   = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/bch_syndrome_gen.sv
// rtl/bch_syndrome_gen.sv - BCH(63,56) serial remainder/syndrome generator, strobes isEn3 per frame
// Optional BCH_ZERO_FLAG_EN adds a registered err_free flag (S==0 and s1==0).
module bch_syndrome_gen
   import bch_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   bch_syndrome_gen_if.slave  bus
);

   localparam logic [BCH_CW-1:0] LAST = BCH_CW'(BCH_N - 1);
   localparam logic [BCH_CW-1:0] ONE  = BCH_CW'(1);

   bch_state_e        state_q, state_d;
   logic [BCH_CW-1:0] count_q, count_d;
   logic [BCH_R-1:0]  accs_q, accs_d, accs_nxt;
   logic [BCH_R-1:0]  S_q, S_d;
   logic [BCH_M-1:0]  s1_q, s1_d, s1_nxt;
   logic [BCH_M-1:0]  s2_q, s2_d, s2_nxt;
   logic              isEn3_q, isEn3_d;
   logic              accept;
   logic              seed;
   logic              done;

   assign accept = bus.din_valid;
   // A new frame starts on sof, or on any accepted bit while idle.
   assign seed   = bus.sof | (state_q == ST_IDLE);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      done    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_ACC;
               count_d = ONE;
            end
         end
         ST_ACC: begin
            if (accept) begin
               if (bus.sof) begin
                  count_d = ONE;
               end else if (count_q == LAST) begin
                  done    = 1'b1;
                  state_d = ST_IDLE;
                  count_d = '0;
               end else begin
                  count_d = count_q + ONE;
               end
            end
         end
      endcase
   end

   always_comb begin
      accs_nxt = lfsr_step(seed ? '0 : accs_q, bus.din);
      accs_d   = accs_q;
      if (done) begin
         accs_d = '0;
      end else if (accept) begin
         accs_d = accs_nxt;
      end
   end

   // Results latch the value including the final bit on the accepting edge.
   always_comb begin
      S_d     = S_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      isEn3_d = done;
      if (done) begin
         S_d  = accs_nxt;
         s1_d = s1_nxt;
         s2_d = s2_nxt;
      end
   end

   bch_horner_cell #(.POW(1)) u_s1_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (accept),
      .seed    (seed),
      .clr     (done),
      .din     (bus.din),
      .acc_nxt (s1_nxt)
   );

   bch_horner_cell #(.POW(2)) u_s2_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (accept),
      .seed    (seed),
      .clr     (done),
      .din     (bus.din),
      .acc_nxt (s2_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         accs_q  <= '0;
         S_q     <= '0;
         s1_q    <= '0;
         s2_q    <= '0;
         isEn3_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         accs_q  <= accs_d;
         S_q     <= S_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         isEn3_q <= isEn3_d;
      end
   end

   assign bus.S     = S_q;
   assign bus.s1    = s1_q;
   assign bus.s2    = s2_q;
   assign bus.isEn3 = isEn3_q;

`ifdef BCH_ZERO_FLAG_EN
   logic err_free_q, err_free_d;

   always_comb begin
      err_free_d = err_free_q;
      if (done) begin
         err_free_d = (accs_nxt == '0) && (s1_nxt == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_free_q <= 1'b0;
      end else begin
         err_free_q <= err_free_d;
      end
   end

   assign bus.err_free = err_free_q;
`endif

endmodule
